// File: rtl/instr_memory.sv
// instr_memory: read-only instruction ROM with a registered output and one-cycle read latency.
// The ROM image is supplied via INIT_DATA, word a at INIT_DATA[a]; the default is an all-zero (NOP) ROM.
module instr_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter logic [DEPTH-1:0][DATA_W-1:0] INIT_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_IRAM,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] instr_out
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic              w_hit;
    logic [IW-1:0]     w_idx;
    logic [DATA_W-1:0] r_instr;

    // Out-of-range addresses read as NOP; there is no aliasing into the implemented words.
    assign w_hit = 32'(addr) < 32'(DEPTH);
    assign w_idx = IW'(addr);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_instr <= '0;
        else if (read_IRAM)
            r_instr <= w_hit ? INIT_DATA[w_idx] : '0;
    end

    assign instr_out = r_instr;
endmodule

// File: tb/tb_instr_memory.sv
// tb_instr_memory: randomized and directed scoreboard bench for instr_memory.
// Two instances run side by side: one with DEPTH=256 and one with DEPTH=64.
module tb_instr_memory;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd = 1'b1;
    logic [7:0] addr = 8'd3;
    logic [7:0] q0, q1;

    logic [7:0] exp0_q[$], exp1_q[$];
    string      lab_q[$];
    logic [7:0] m0 = 8'h00, m1 = 8'h00;
    string      phase = "reset";
    int         n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [255:0][7:0] mk_img();
        logic [255:0][7:0] v;
        for (int a = 0; a < 256; a++) v[a] = 8'(a) ^ 8'h5A;
        return v;
    endfunction

    localparam logic [255:0][7:0] IMG   = mk_img();
    localparam logic [63:0][7:0]  IMG64 = IMG[63:0];

    instr_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_DATA(IMG)) u0 (
        .clk(clk), .rst_n(rst_n), .read_IRAM(rd), .addr(addr), .instr_out(q0));
    instr_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(64), .INIT_DATA(IMG64)) u1 (
        .clk(clk), .rst_n(rst_n), .read_IRAM(rd), .addr(addr), .instr_out(q1));

    // Reference: image word a is a ^ 0x5A inside the implemented depth, NOP beyond it.
    function automatic logic [7:0] ref_word(input int a, input int d);
        return (a < d) ? 8'(a ^ 'h5A) : 8'h00;
    endfunction

    task automatic step(input logic r, input logic e, input logic [7:0] a);
        @(negedge clk);
        rst_n = r;
        rd    = e;
        addr  = a;
        if (!r) begin
            m0 = 8'h00;
            m1 = 8'h00;
        end else if (e) begin
            m0 = ref_word(int'(a), 256);
            m1 = ref_word(int'(a), 64);
        end
        exp0_q.push_back(m0);
        exp1_q.push_back(m1);
        lab_q.push_back(phase);
    endtask

    // Monitor: the DUT presents a word after every edge; compare it once it has settled.
    always @(posedge clk) begin
        #1;
        if (exp0_q.size() > 0) begin
            logic [7:0] e0, e1;
            string      l;
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            l  = lab_q.pop_front();
            n_tests += 2;
            if (q0 !== e0) begin
                n_fail++;
                $display("FAIL %s d256: got %02h expected %02h", l, q0, e0);
            end
            if (q1 !== e1) begin
                n_fail++;
                $display("FAIL %s d64: got %02h expected %02h", l, q1, e1);
            end
        end
    end

    initial begin
        phase = "reset";
        step(1'b0, 1'b1, 8'd3);
        step(1'b0, 1'b1, 8'd3);
        phase = "read_after_reset";
        step(1'b1, 1'b1, 8'd3);
        phase = "gate";
        step(1'b0, 1'b1, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'd0);
        phase = "hold";
        step(1'b1, 1'b1, 8'd1);
        for (int a = 2; a <= 5; a++) step(1'b1, 1'b0, 8'(a));
        step(1'b1, 1'b0, 8'hxx);
        phase = "stream";
        for (int a = 0; a <= 80; a++) step(1'b1, 1'b1, 8'(a));
        phase = "boundary";
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'd64);
        step(1'b1, 1'b1, 8'd63);
        step(1'b1, 1'b1, 8'd0);
        phase = "midreset";
        for (int a = 0; a < 20; a++) step(a != 10, 1'b1, 8'(a + 40));
        phase = "random";
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        phase = "drain";
        step(1'b1, 1'b0, 8'd0);
        @(negedge clk);
        n_tests++;
        if (exp0_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp0_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
